// File: rtl/buffer_reserve_ctrl_if.sv
// Handshake bundle between the AHB register block / RX datapath / FIFO counter
// and the buffer reservation arbiter.
interface buffer_reserve_ctrl_if #(
    parameter int CNT_W = 7
);
    logic             txPacketSizeChanged;
    logic [CNT_W-1:0] txPacketDataSize;
    logic             rxDataReady;
    logic [CNT_W-1:0] bufferOccupancy;
    logic             clearRequest;
    logic             bufferReserved;
    logic [1:0]       reserveMode;
    logic             flushBuffer;
    logic             rxPending;
    logic             timeoutError;
    logic             sizeError;

    // Event inputs are single-cycle pulses with no back-pressure: a pulse is
    // consumed on the rising edge it is present at, whether or not it is acted on.
    modport master (
        output txPacketSizeChanged,
        output txPacketDataSize,
        output rxDataReady,
        output bufferOccupancy,
        output clearRequest,
        input  bufferReserved,
        input  reserveMode,
        input  flushBuffer,
        input  rxPending,
        input  timeoutError,
        input  sizeError
    );

    modport slave (
        input  txPacketSizeChanged,
        input  txPacketDataSize,
        input  rxDataReady,
        input  bufferOccupancy,
        input  clearRequest,
        output bufferReserved,
        output reserveMode,
        output flushBuffer,
        output rxPending,
        output timeoutError,
        output sizeError
    );
endinterface

// File: rtl/buffer_reserve_ctrl.sv
// Reserves the shared USB/AHB packet buffer for one direction at a time (TX fill,
// RX drain or flush), with size checking, stall timeout and a pending-RX latch.
module buffer_reserve_ctrl #(
    parameter int DEPTH   = 64,
    parameter int CNT_W   = $clog2(DEPTH + 1),
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = $clog2(TIMEOUT + 2)
) (
    input logic                  clk,
    input logic                  nRst,
    buffer_reserve_ctrl_if.slave bus
);

    // Encoding equals reserveMode, so the state is always visible on that output.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WRITE = 2'b01,
        S_READ  = 2'b10,
        S_FLUSH = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] occ_q;
    logic [TO_W-1:0]  stall_q, stall_d;
    logic             rx_pend_q, rx_pend_d;
    logic             to_err_q, to_err_d;
    logic             sz_err_q, sz_err_d;

    logic tx_start;
    logic size_illegal;
    logic occ_moved;
    logic stall_hit;
    logic busy_q;

    assign tx_start     = bus.txPacketSizeChanged;
    assign size_illegal = (bus.txPacketDataSize == '0) || (bus.txPacketDataSize > DEPTH_C);
    assign occ_moved    = (bus.bufferOccupancy != occ_q);
    assign busy_q       = (state_q == S_WRITE) || (state_q == S_READ);

    // The abort fires on the edge at which the counter would reach TIMEOUT.
    if (TIMEOUT == 0) begin : g_no_timeout
        assign stall_hit = 1'b0;
    end else begin : g_timeout
        assign stall_hit = !occ_moved && (stall_q == TO_W'(TIMEOUT - 1));
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        to_err_d = 1'b0;
        sz_err_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.clearRequest) begin
                    state_d = S_FLUSH;
                end else if (tx_start && size_illegal) begin
                    sz_err_d = 1'b1;
                end else if (tx_start) begin
                    target_d = bus.txPacketDataSize;
                    state_d  = S_WRITE;
                end else if (bus.rxDataReady || rx_pend_q) begin
                    state_d = S_READ;
                end
            end
            S_WRITE: begin
                if (bus.clearRequest) begin
                    state_d = S_FLUSH;
                end else if (bus.bufferOccupancy > target_q) begin
                    state_d  = S_FLUSH;
                    sz_err_d = 1'b1;
                end else if (bus.bufferOccupancy == target_q) begin
                    state_d = S_IDLE;
                end else if (stall_hit) begin
                    state_d  = S_FLUSH;
                    to_err_d = 1'b1;
                end
            end
            S_READ: begin
                if (bus.clearRequest) begin
                    state_d = S_FLUSH;
                end else if (bus.bufferOccupancy == '0) begin
                    state_d = S_IDLE;
                end else if (stall_hit) begin
                    state_d  = S_FLUSH;
                    to_err_d = 1'b1;
                end
            end
            S_FLUSH: begin
                if (bus.bufferOccupancy == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One-bit latch: an RX event that cannot be taken now is remembered until
    // the next entry into READ, unless an abort discards it.
    always_comb begin
        rx_pend_d = rx_pend_q;
        if (bus.clearRequest) begin
            rx_pend_d = 1'b0;
        end else if ((state_q == S_IDLE) && (state_d == S_READ)) begin
            rx_pend_d = 1'b0;
        end else if (bus.rxDataReady) begin
            rx_pend_d = 1'b1;
        end
    end

    always_comb begin
        stall_d = '0;
        if ((TIMEOUT != 0) && busy_q && (state_d == state_q) && !occ_moved) begin
            stall_d = stall_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= S_IDLE;
            target_q  <= '0;
            occ_q     <= '0;
            stall_q   <= '0;
            rx_pend_q <= 1'b0;
            to_err_q  <= 1'b0;
            sz_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            occ_q     <= bus.bufferOccupancy;
            stall_q   <= stall_d;
            rx_pend_q <= rx_pend_d;
            to_err_q  <= to_err_d;
            sz_err_q  <= sz_err_d;
        end
    end

    assign bus.bufferReserved = (state_q != S_IDLE);
    assign bus.reserveMode    = state_q;
    assign bus.flushBuffer    = (state_q == S_FLUSH);
    assign bus.rxPending      = rx_pend_q;
    assign bus.timeoutError   = to_err_q;
    assign bus.sizeError      = sz_err_q;

endmodule

// File: tb/tb_buffer_reserve_ctrl.sv
// Bench for buffer_reserve_ctrl: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the reservation rules.
module tb_buffer_reserve_ctrl;
    localparam int DEPTH   = 64;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int TIMEOUT = 16;

    localparam int M_IDLE  = 0;
    localparam int M_WRITE = 1;
    localparam int M_READ  = 2;
    localparam int M_FLUSH = 3;

    logic clk  = 1'b0;
    logic nRst = 1'b0;
    always #5 clk = ~clk;

    buffer_reserve_ctrl_if #(.CNT_W(CNT_W)) bus ();

    buffer_reserve_ctrl #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [6:0] exp_q[$];

    // Reference model state
    int m_mode, m_target, m_prev_occ, m_quiet;
    bit m_pend, m_to, m_sz;

    function automatic logic [6:0] obs();
        return {bus.bufferReserved, bus.reserveMode, bus.flushBuffer,
                bus.rxPending, bus.timeoutError, bus.sizeError};
    endfunction

    function automatic logic [6:0] ev(input int mode, input bit pend, input bit to, input bit sz);
        logic [1:0] m;
        m = mode[1:0];
        return {mode != M_IDLE, m, mode == M_FLUSH, pend, to, sz};
    endfunction

    task automatic drive(input bit tx, input int sz, input bit rx, input int occ, input bit clr);
        bus.txPacketSizeChanged = tx;
        bus.txPacketDataSize    = CNT_W'(sz);
        bus.rxDataReady         = rx;
        bus.bufferOccupancy     = CNT_W'(occ);
        bus.clearRequest        = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_target = 0; m_prev_occ = 0; m_quiet = 0;
        m_pend = 0; m_to = 0; m_sz = 0;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        nRst = 1'b0;
        repeat (2) @(posedge clk);
        #1 nRst = 1'b1;
        model_reset();
    endtask

    // One rising edge of the reservation rules, given the inputs present at it.
    task automatic model_step(input bit tx, input int sz, input bit rx, input int occ, input bit clr);
        int  nxt;
        bit  to, se, moved;
        nxt = m_mode; to = 0; se = 0;
        moved = (occ != m_prev_occ);
        if (m_mode == M_IDLE) begin
            if (clr) nxt = M_FLUSH;
            else if (tx && (sz == 0 || sz > DEPTH)) se = 1;
            else if (tx) begin m_target = sz; nxt = M_WRITE; end
            else if (rx || m_pend) nxt = M_READ;
        end else if (m_mode == M_FLUSH) begin
            if (occ == 0) nxt = M_IDLE;
        end else begin
            int done_at;
            done_at = (m_mode == M_WRITE) ? m_target : 0;
            if (clr) nxt = M_FLUSH;
            else if (m_mode == M_WRITE && occ > m_target) begin nxt = M_FLUSH; se = 1; end
            else if (occ == done_at) nxt = M_IDLE;
            else if (TIMEOUT != 0 && !moved && m_quiet + 1 >= TIMEOUT) begin nxt = M_FLUSH; to = 1; end
        end
        if (nxt != m_mode || moved || !(nxt == M_WRITE || nxt == M_READ)) m_quiet = 0;
        else m_quiet = m_quiet + 1;
        if (clr) m_pend = 0;
        else if (m_mode == M_IDLE && nxt == M_READ) m_pend = 0;
        else if (rx) m_pend = 1;
        m_mode = nxt; m_to = to; m_sz = se; m_prev_occ = occ;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0);
        nRst = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 7'b0) begin n_fail++; $display("FAIL reset_hold: got %b want %b", obs(), 7'b0); end
        do_reset();
        tick();
        n_checks++;
        if (obs() !== ev(M_IDLE, 0, 0, 0)) begin n_fail++; $display("FAIL reset_idle: got %b want %b", obs(), ev(M_IDLE, 0, 0, 0)); end
    endtask

    task automatic test_tx();
        do_reset();
        drive(1, 8, 0, 0, 0);
        tick();
        n_checks++;
        if (obs() !== ev(M_WRITE, 0, 0, 0)) begin n_fail++; $display("FAIL tx_start: got %b want %b", obs(), ev(M_WRITE, 0, 0, 0)); end
        for (int k = 1; k <= 8; k++) begin
            drive(0, 8, 0, k, 0);
            tick();
            n_checks++;
            if (obs() !== ev(k == 8 ? M_IDLE : M_WRITE, 0, 0, 0)) begin
                n_fail++; $display("FAIL tx_ramp occ=%0d: got %b want %b", k, obs(), ev(k == 8 ? M_IDLE : M_WRITE, 0, 0, 0));
            end
        end
    endtask

    task automatic test_illegal_size();
        int sizes[2];
        sizes[0] = 0; sizes[1] = DEPTH + 1;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, sizes[i], 0, 0, 0);
            tick();
            n_checks++;
            if (obs() !== ev(M_IDLE, 0, 0, 1)) begin n_fail++; $display("FAIL illegal_pulse size=%0d: got %b want %b", sizes[i], obs(), ev(M_IDLE, 0, 0, 1)); end
            drive(0, 0, 0, 0, 0);
            tick();
            n_checks++;
            if (obs() !== ev(M_IDLE, 0, 0, 0)) begin n_fail++; $display("FAIL illegal_after size=%0d: got %b want %b", sizes[i], obs(), ev(M_IDLE, 0, 0, 0)); end
        end
        drive(1, DEPTH, 0, 0, 0);
        tick();
        n_checks++;
        if (obs() !== ev(M_WRITE, 0, 0, 0)) begin n_fail++; $display("FAIL full_size_legal: got %b want %b", obs(), ev(M_WRITE, 0, 0, 0)); end
    endtask

    task automatic test_overrun();
        do_reset();
        drive(1, 4, 0, 0, 0); tick();
        drive(0, 4, 0, 3, 0); tick();
        n_checks++;
        if (obs() !== ev(M_WRITE, 0, 0, 0)) begin n_fail++; $display("FAIL overrun_pre: got %b want %b", obs(), ev(M_WRITE, 0, 0, 0)); end
        drive(0, 4, 0, 5, 0); tick();
        n_checks++;
        if (obs() !== ev(M_FLUSH, 0, 0, 1)) begin n_fail++; $display("FAIL overrun_flush: got %b want %b", obs(), ev(M_FLUSH, 0, 0, 1)); end
        tick();
        n_checks++;
        if (obs() !== ev(M_FLUSH, 0, 0, 0)) begin n_fail++; $display("FAIL overrun_hold: got %b want %b", obs(), ev(M_FLUSH, 0, 0, 0)); end
        drive(0, 4, 0, 0, 0); tick();
        n_checks++;
        if (obs() !== ev(M_IDLE, 0, 0, 0)) begin n_fail++; $display("FAIL overrun_drain: got %b want %b", obs(), ev(M_IDLE, 0, 0, 0)); end
    endtask

    task automatic test_stall();
        do_reset();
        drive(0, 0, 1, 10, 0); tick();
        n_checks++;
        if (obs() !== ev(M_READ, 0, 0, 0)) begin n_fail++; $display("FAIL stall_read: got %b want %b", obs(), ev(M_READ, 0, 0, 0)); end
        drive(0, 0, 0, 9, 0); tick();
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            if (i >= TIMEOUT - 1) begin
                n_checks++;
                if (obs() !== ev(i == TIMEOUT ? M_FLUSH : M_READ, 0, i == TIMEOUT, 0)) begin
                    n_fail++; $display("FAIL stall_edge %0d: got %b want %b", i, obs(), ev(i == TIMEOUT ? M_FLUSH : M_READ, 0, i == TIMEOUT, 0));
                end
            end
        end
        tick();
        n_checks++;
        if (obs() !== ev(M_FLUSH, 0, 0, 0)) begin n_fail++; $display("FAIL stall_pulse_end: got %b want %b", obs(), ev(M_FLUSH, 0, 0, 0)); end
        drive(0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive(1, 4, 1, 0, 0); tick();
        n_checks++;
        if (obs() !== ev(M_WRITE, 1, 0, 0)) begin n_fail++; $display("FAIL simul_start: got %b want %b", obs(), ev(M_WRITE, 1, 0, 0)); end
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, k, 0); tick();
        end
        n_checks++;
        if (obs() !== ev(M_IDLE, 1, 0, 0)) begin n_fail++; $display("FAIL simul_idle: got %b want %b", obs(), ev(M_IDLE, 1, 0, 0)); end
        tick();
        n_checks++;
        if (obs() !== ev(M_READ, 0, 0, 0)) begin n_fail++; $display("FAIL simul_read: got %b want %b", obs(), ev(M_READ, 0, 0, 0)); end
        drive(0, 0, 0, 0, 0); tick();
        n_checks++;
        if (obs() !== ev(M_IDLE, 0, 0, 0)) begin n_fail++; $display("FAIL simul_done: got %b want %b", obs(), ev(M_IDLE, 0, 0, 0)); end
    endtask

    task automatic test_clear_in_write();
        do_reset();
        drive(1, 8, 1, 0, 0); tick();
        drive(0, 8, 0, 2, 0); tick();
        n_checks++;
        if (obs() !== ev(M_WRITE, 1, 0, 0)) begin n_fail++; $display("FAIL clear_pre: got %b want %b", obs(), ev(M_WRITE, 1, 0, 0)); end
        drive(0, 8, 1, 2, 1); tick();
        n_checks++;
        if (obs() !== ev(M_FLUSH, 0, 0, 0)) begin n_fail++; $display("FAIL clear_flush: got %b want %b", obs(), ev(M_FLUSH, 0, 0, 0)); end
        drive(0, 8, 0, 0, 0); tick();
        n_checks++;
        if (obs() !== ev(M_IDLE, 0, 0, 0)) begin n_fail++; $display("FAIL clear_done: got %b want %b", obs(), ev(M_IDLE, 0, 0, 0)); end
    endtask

    task automatic test_reset_in_read();
        do_reset();
        drive(0, 0, 1, 5, 0); tick();
        drive(0, 0, 1, 5, 0); tick();
        n_checks++;
        if (obs() !== ev(M_READ, 1, 0, 0)) begin n_fail++; $display("FAIL rst_read_pre: got %b want %b", obs(), ev(M_READ, 1, 0, 0)); end
        drive(0, 0, 0, 5, 0);
        #2 nRst = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 7'b0) begin n_fail++; $display("FAIL rst_async: got %b want %b", obs(), 7'b0); end
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #1 nRst = 1'b1;
        tick();
        n_checks++;
        if (obs() !== ev(M_IDLE, 0, 0, 0)) begin n_fail++; $display("FAIL rst_release: got %b want %b", obs(), ev(M_IDLE, 0, 0, 0)); end
    endtask

    task automatic test_random();
        int occ, sz, r;
        bit tx, rx, clr;
        logic [6:0] e;
        occ = 0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            tx  = ($urandom_range(0, 7) == 0);
            sz  = $urandom_range(0, DEPTH + 2);
            rx  = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 24) == 0);
            r   = $urandom_range(0, 9);
            if ((c % 300) >= 270) begin
                tx = 0; rx = 0; clr = 0; r = 0;
            end
            case (r)
                4, 5:    if (occ < DEPTH) occ++;
                6:       if (occ > 0) occ--;
                7:       occ = 0;
                8:       occ = $urandom_range(0, DEPTH);
                default: ;
            endcase
            drive(tx, sz, rx, occ, clr);
            @(posedge clk);
            model_step(tx, sz, rx, occ, clr);
            exp_q.push_back(ev(m_mode, m_pend, m_to, m_sz));
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL random cycle %0d: got %b want %b", c, obs(), e);
            end
        end
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tx();
        test_illegal_size();
        test_overrun();
        test_stall();
        test_simultaneous();
        test_clear_in_write();
        test_reset_in_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
